// File: rtl/draw_sequencer_pkg.sv
// Shared definitions for the draw sequencer: state encoding, pixel widths,
// default parameters and the mask search helper.
package draw_sequencer_pkg;

  localparam int NUM_SRC_DEF = 4;
  localparam int TIMEOUT_DEF = 65536;
  localparam int X_W         = 9;
  localparam int Y_W         = 8;
  localparam int C_W         = 12;
  localparam int WD_W        = 17;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    ADVANCE,
    FINISH
  } state_e;

  // Returns {found, index} of the lowest set mask bit at or above 'from'.
  function automatic logic [2:0] find_set(input logic [3:0] mask, input logic [2:0] from);
    logic [2:0] res;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i] && (3'(i) >= from)) res = {1'b1, 2'(i)};
    end
    return res;
  endfunction

endpackage

// File: rtl/draw_watchdog.sv
// Per-source watchdog: restarts on clear, counts up once per cycle and
// saturates at TIMEOUT-1, where it reports expiry.
module draw_watchdog
  import draw_sequencer_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic expired
);

  localparam logic [WD_W-1:0] LIMIT = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] count_q, count_d;

  // NOTE: combinational blocks assign every output a default first, so no
  // path through the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clear)                count_d = '0;
    else if (count_q != LIMIT) count_d = count_q + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign expired = (count_q == LIMIT);

endmodule

// File: rtl/draw_sequencer.sv
// Frame draw sequencer: starts each selected source in ascending order, waits
// for its done pulse (or a watchdog expiry) and muxes its pixels to the VGA.
module draw_sequencer
  import draw_sequencer_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_req,
  input  logic [NUM_SRC-1:0]     src_mask,
  output logic [NUM_SRC-1:0]     enable_draw,
  input  logic [NUM_SRC-1:0]     src_done,
  input  logic [NUM_SRC*X_W-1:0] src_x,
  input  logic [NUM_SRC*Y_W-1:0] src_y,
  input  logic [NUM_SRC*C_W-1:0] src_color,
  input  logic [NUM_SRC-1:0]     src_we,
  output logic [X_W-1:0]         X_out,
  output logic [Y_W-1:0]         Y_out,
  output logic [C_W-1:0]         Color_out,
  output logic                   writeEn_out,
  output logic                   frame_busy,
  output logic                   frame_done,
  output logic                   timeout_err
);

  state_e               state_q, state_d;
  logic [NUM_SRC-1:0]   mask_q, mask_d;
  logic [1:0]           idx_q, idx_d;
  logic                 pending_q, pending_d;
  logic [NUM_SRC-1:0]   enable_draw_q, enable_draw_d;
  logic                 frame_busy_q, frame_busy_d;
  logic                 frame_done_q, frame_done_d;
  logic                 timeout_err_q, timeout_err_d;
  logic [X_W-1:0]       x_q, x_d;
  logic [Y_W-1:0]       y_q, y_d;
  logic [C_W-1:0]       color_q, color_d;
  logic                 we_q, we_d;
  logic                 wd_clear, wd_expired;
  logic [2:0]           nxt;

  draw_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wd_clear),
    .expired (wd_expired)
  );

  always_comb begin
    state_d       = state_q;
    mask_d        = mask_q;
    idx_d         = idx_q;
    pending_d     = pending_q;
    enable_draw_d = '0;
    frame_busy_d  = (state_q != IDLE);
    frame_done_d  = 1'b0;
    timeout_err_d = timeout_err_q;
    x_d           = x_q;
    y_d           = y_q;
    color_d       = color_q;
    we_d          = 1'b0;
    wd_clear      = 1'b0;
    nxt           = '0;

    // One-deep request queue; a second request while one is pending is lost.
    if (frame_req && (state_q != IDLE)) pending_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (frame_req || pending_q) begin
          mask_d    = src_mask;
          pending_d = 1'b0;
          nxt       = find_set(src_mask, 3'd0);
          idx_d     = nxt[1:0];
          state_d   = nxt[2] ? ISSUE : FINISH;
        end
      end
      ISSUE: begin
        enable_draw_d[idx_q] = 1'b1;
        wd_clear             = 1'b1;
        state_d              = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (src_we[idx_q]) begin
          we_d    = 1'b1;
          x_d     = src_x[int'(idx_q)*X_W +: X_W];
          y_d     = src_y[int'(idx_q)*Y_W +: Y_W];
          color_d = src_color[int'(idx_q)*C_W +: C_W];
        end
        // A done arriving together with expiry wins and raises no error.
        if (src_done[idx_q]) begin
          state_d = ADVANCE;
        end else if (wd_expired) begin
          state_d       = ADVANCE;
          timeout_err_d = 1'b1;
        end
      end
      ADVANCE: begin
        nxt = find_set(mask_q, {1'b0, idx_q} + 3'd1);
        if (nxt[2]) begin
          idx_d   = nxt[1:0];
          state_d = ISSUE;
        end else begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        frame_done_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      mask_q        <= '0;
      idx_q         <= '0;
      pending_q     <= 1'b0;
      enable_draw_q <= '0;
      frame_busy_q  <= 1'b0;
      frame_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      color_q       <= '0;
      we_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      mask_q        <= mask_d;
      idx_q         <= idx_d;
      pending_q     <= pending_d;
      enable_draw_q <= enable_draw_d;
      frame_busy_q  <= frame_busy_d;
      frame_done_q  <= frame_done_d;
      timeout_err_q <= timeout_err_d;
      x_q           <= x_d;
      y_q           <= y_d;
      color_q       <= color_d;
      we_q          <= we_d;
    end
  end

  // Control outputs come straight from flops so sources see clean pulses.
  assign enable_draw = enable_draw_q;
  assign frame_busy  = frame_busy_q;
  assign frame_done  = frame_done_q;
  assign timeout_err = timeout_err_q;
  assign X_out       = x_q;
  assign Y_out       = y_q;
  assign Color_out   = color_q;
  assign writeEn_out = we_q;

endmodule

// File: tb/tb_draw_sequencer.sv
// Directed bench for draw_sequencer: a default-parameter instance for the
// functional scenarios and a TIMEOUT=16 instance for the watchdog scenarios.
module tb_draw_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_req = 1'b0;
  logic [3:0]  src_mask = '0;
  logic [3:0]  src_done = '0;
  logic [3:0]  src_we = '0;
  logic [35:0] src_x = '0;
  logic [31:0] src_y = '0;
  logic [47:0] src_color = '0;

  logic [3:0]  enable_draw, t_enable_draw;
  logic [8:0]  X_out, t_X_out;
  logic [7:0]  Y_out, t_Y_out;
  logic [11:0] Color_out, t_Color_out;
  logic        writeEn_out, t_writeEn_out;
  logic        frame_busy, t_frame_busy;
  logic        frame_done, t_frame_done;
  logic        timeout_err, t_timeout_err;

  int n_checks = 0;
  int n_fail = 0;
  int fd_cnt = 0;
  int t_fd_cnt = 0;
  logic [3:0] en_log[$];

  draw_sequencer dut (
    .clk(clk), .reset(reset), .frame_req(frame_req), .src_mask(src_mask),
    .enable_draw(enable_draw), .src_done(src_done), .src_x(src_x), .src_y(src_y),
    .src_color(src_color), .src_we(src_we), .X_out(X_out), .Y_out(Y_out),
    .Color_out(Color_out), .writeEn_out(writeEn_out), .frame_busy(frame_busy),
    .frame_done(frame_done), .timeout_err(timeout_err)
  );

  draw_sequencer #(.TIMEOUT(16)) dut_t (
    .clk(clk), .reset(reset), .frame_req(frame_req), .src_mask(src_mask),
    .enable_draw(t_enable_draw), .src_done(src_done), .src_x(src_x), .src_y(src_y),
    .src_color(src_color), .src_we(src_we), .X_out(t_X_out), .Y_out(t_Y_out),
    .Color_out(t_Color_out), .writeEn_out(t_writeEn_out), .frame_busy(t_frame_busy),
    .frame_done(t_frame_done), .timeout_err(t_timeout_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      if (enable_draw != 4'b0000) en_log.push_back(enable_draw);
      if (frame_done) fd_cnt++;
      if (t_frame_done) t_fd_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    frame_req = 1'b0;
    src_mask = '0;
    src_done = '0;
    src_we = '0;
    src_x = '0;
    src_y = '0;
    src_color = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic wait_en(input int budget, output logic [3:0] v);
    v = '0;
    for (int i = 0; i < budget && v == 4'b0000; i++) begin
      tick();
      v = enable_draw;
    end
  endtask

  task automatic wait_t_en(input int budget, output logic [3:0] v);
    v = '0;
    for (int i = 0; i < budget && v == 4'b0000; i++) begin
      tick();
      v = t_enable_draw;
    end
  endtask

  task automatic wait_fd(input int budget, output logic seen);
    seen = frame_done;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      seen = frame_done;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    if ({enable_draw, writeEn_out, frame_busy, frame_done, timeout_err} !== 8'h00) begin
      $display("FAIL reset_ctrl: got %b expected 00000000",
               {enable_draw, writeEn_out, frame_busy, frame_done, timeout_err});
      n_fail++;
    end
    n_checks++;
    do_reset();
    if ({X_out, Y_out, Color_out} !== 29'd0) begin
      $display("FAIL reset_pixel: got %h expected 0", {X_out, Y_out, Color_out});
      n_fail++;
    end
    n_checks++;
    if (frame_busy !== 1'b0 || t_timeout_err !== 1'b0) begin
      $display("FAIL reset_idle: busy %b err %b expected 0 0", frame_busy, t_timeout_err);
      n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_two_sources();
    logic [3:0] v;
    logic seen;
    int e0, f0;
    do_reset();
    e0 = en_log.size();
    f0 = fd_cnt;
    src_mask = 4'b0101;
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    src_mask = 4'b1111;  // mid-frame change must not affect this frame
    wait_en(10, v);
    if (v !== 4'b0001) begin
      $display("FAIL two_src_en0: got %b expected 0001", v);
      n_fail++;
    end
    n_checks++;
    if (frame_busy !== 1'b1) begin
      $display("FAIL two_src_busy: got %b expected 1", frame_busy);
      n_fail++;
    end
    n_checks++;
    repeat (9) tick();
    src_done = 4'b0001;
    tick();
    src_done = 4'b0000;
    wait_en(10, v);
    if (v !== 4'b0100) begin
      $display("FAIL two_src_en2: got %b expected 0100", v);
      n_fail++;
    end
    n_checks++;
    repeat (19) tick();
    src_done = 4'b0100;
    tick();
    src_done = 4'b0000;
    wait_fd(10, seen);
    if (seen !== 1'b1) begin
      $display("FAIL two_src_done: got %b expected 1", seen);
      n_fail++;
    end
    n_checks++;
    tick();
    if (frame_done !== 1'b0 || frame_busy !== 1'b0) begin
      $display("FAIL two_src_end: done %b busy %b expected 0 0", frame_done, frame_busy);
      n_fail++;
    end
    n_checks++;
    if (en_log.size() - e0 !== 2 || fd_cnt - f0 !== 1 || timeout_err !== 1'b0) begin
      $display("FAIL two_src_counts: enables %0d frames %0d err %b expected 2 1 0",
               en_log.size() - e0, fd_cnt - f0, timeout_err);
      n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_pixel_mux();
    logic [3:0] v;
    logic seen;
    int e0;
    do_reset();
    src_mask = 4'b0110;
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    wait_en(10, v);
    if (v !== 4'b0010) begin
      $display("FAIL pix_en1: got %b expected 0010", v);
      n_fail++;
    end
    n_checks++;
    src_x[9 +: 9] = 9'd100;
    src_y[8 +: 8] = 8'd60;
    src_color[12 +: 12] = 12'hF00;
    src_x[18 +: 9] = 9'd7;
    src_y[16 +: 8] = 8'd7;
    src_color[24 +: 12] = 12'hABC;
    src_we = 4'b0110;
    #1;
    if (writeEn_out !== 1'b0) begin
      $display("FAIL pix_no_zero_latency: got %b expected 0", writeEn_out);
      n_fail++;
    end
    n_checks++;
    tick();
    if ({writeEn_out, X_out, Y_out, Color_out} !== {1'b1, 9'd100, 8'd60, 12'hF00}) begin
      $display("FAIL pix_write: we %b x %0d y %0d c %h expected 1 100 60 f00",
               writeEn_out, X_out, Y_out, Color_out);
      n_fail++;
    end
    n_checks++;
    e0 = en_log.size();
    src_we = 4'b0100;
    src_done = 4'b0100;
    src_x[9 +: 9] = 9'd5;
    tick();
    src_we = 4'b0000;
    src_done = 4'b0000;
    if ({writeEn_out, X_out, Y_out, Color_out} !== {1'b0, 9'd100, 8'd60, 12'hF00}) begin
      $display("FAIL pix_other_src: we %b x %0d y %0d c %h expected 0 100 60 f00",
               writeEn_out, X_out, Y_out, Color_out);
      n_fail++;
    end
    n_checks++;
    repeat (4) tick();
    if (en_log.size() !== e0 || frame_busy !== 1'b1) begin
      $display("FAIL pix_done_ignored: enables %0d busy %b expected %0d 1",
               en_log.size(), frame_busy, e0);
      n_fail++;
    end
    n_checks++;
    src_done = 4'b0010;
    tick();
    src_done = 4'b0000;
    wait_en(10, v);
    if (v !== 4'b0100) begin
      $display("FAIL pix_en2: got %b expected 0100", v);
      n_fail++;
    end
    n_checks++;
    src_we = 4'b0100;
    tick();
    src_we = 4'b0000;
    if ({writeEn_out, X_out, Y_out, Color_out} !== {1'b1, 9'd7, 8'd7, 12'hABC}) begin
      $display("FAIL pix_src2: we %b x %0d y %0d c %h expected 1 7 7 abc",
               writeEn_out, X_out, Y_out, Color_out);
      n_fail++;
    end
    n_checks++;
    src_done = 4'b0100;
    tick();
    src_done = 4'b0000;
    wait_fd(10, seen);
    if (seen !== 1'b1) begin
      $display("FAIL pix_frame_done: got %b expected 1", seen);
      n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_timeout();
    logic [3:0] v;
    int n;
    do_reset();
    src_mask = 4'b0001;
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    wait_t_en(10, v);
    if (v !== 4'b0001) begin
      $display("FAIL to_en0: got %b expected 0001", v);
      n_fail++;
    end
    n_checks++;
    n = 0;
    while (!t_timeout_err && n < 40) begin
      tick();
      n++;
    end
    if (n !== 16) begin
      $display("FAIL to_cycles: got %0d expected 16", n);
      n_fail++;
    end
    n_checks++;
    tick();
    tick();
    if (t_frame_done !== 1'b1) begin
      $display("FAIL to_frame_done: got %b expected 1", t_frame_done);
      n_fail++;
    end
    n_checks++;
    repeat (5) tick();
    if (t_timeout_err !== 1'b1 || t_frame_busy !== 1'b0 || timeout_err !== 1'b0) begin
      $display("FAIL to_sticky: err %b busy %b main_err %b expected 1 0 0",
               t_timeout_err, t_frame_busy, timeout_err);
      n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_done_at_timeout();
    logic [3:0] v;
    int f0;
    do_reset();
    f0 = t_fd_cnt;
    src_mask = 4'b0001;
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    wait_t_en(10, v);
    repeat (15) tick();
    src_done = 4'b0001;
    tick();
    src_done = 4'b0000;
    repeat (4) tick();
    if (t_timeout_err !== 1'b0 || t_fd_cnt - f0 !== 1) begin
      $display("FAIL done_at_limit: err %b frames %0d expected 0 1",
               t_timeout_err, t_fd_cnt - f0);
      n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] who;
    int dly, e0, f0;
    do_reset();
    e0 = en_log.size();
    f0 = fd_cnt;
    src_mask = 4'b0001;
    who = '0;
    dly = -1;
    for (int i = 0; i < 60; i++) begin
      frame_req = (i == 0 || i == 3 || i == 5 || i == 7);
      src_done = (dly == 0) ? who : 4'b0000;
      tick();
      if (dly >= 0) dly--;
      if (enable_draw != 4'b0000) begin
        who = enable_draw;
        dly = 6;
      end
    end
    frame_req = 1'b0;
    src_done = 4'b0000;
    if (fd_cnt - f0 !== 2 || en_log.size() - e0 !== 2) begin
      $display("FAIL b2b_frames: frames %0d enables %0d expected 2 2",
               fd_cnt - f0, en_log.size() - e0);
      n_fail++;
    end
    n_checks++;
    if (frame_busy !== 1'b0) begin
      $display("FAIL b2b_idle: busy %b expected 0", frame_busy);
      n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_empty_mask();
    int e0;
    do_reset();
    e0 = en_log.size();
    src_mask = 4'b0000;
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    if (frame_done !== 1'b0) begin
      $display("FAIL empty_early: got %b expected 0", frame_done);
      n_fail++;
    end
    n_checks++;
    tick();
    if (frame_done !== 1'b1) begin
      $display("FAIL empty_done: got %b expected 1", frame_done);
      n_fail++;
    end
    n_checks++;
    tick();
    if (frame_done !== 1'b0 || en_log.size() !== e0) begin
      $display("FAIL empty_after: done %b enables %0d expected 0 %0d",
               frame_done, en_log.size(), e0);
      n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_reset_mid_frame();
    logic [3:0] v;
    int f0;
    do_reset();
    f0 = fd_cnt;
    src_mask = 4'b0100;
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    wait_en(10, v);
    repeat (3) tick();
    src_x[18 +: 9] = 9'd300;
    src_y[16 +: 8] = 8'd200;
    src_color[24 +: 12] = 12'h0F0;
    src_we = 4'b0100;
    tick();
    if (writeEn_out !== 1'b1 || frame_busy !== 1'b1 || X_out !== 9'd300) begin
      $display("FAIL rst_mid_pre: we %b busy %b x %0d expected 1 1 300",
               writeEn_out, frame_busy, X_out);
      n_fail++;
    end
    n_checks++;
    #2 reset = 1'b1;
    #1;
    if ({enable_draw, X_out, Y_out, Color_out, writeEn_out, frame_busy, frame_done,
         timeout_err} !== 37'd0) begin
      $display("FAIL rst_mid_async: got %h expected 0",
               {enable_draw, X_out, Y_out, Color_out, writeEn_out, frame_busy,
                frame_done, timeout_err});
      n_fail++;
    end
    n_checks++;
    src_we = 4'b0000;
    tick();
    tick();
    reset = 1'b0;
    repeat (3) tick();
    if (fd_cnt !== f0 || frame_busy !== 1'b0) begin
      $display("FAIL rst_mid_no_done: frames %0d busy %b expected %0d 0",
               fd_cnt, frame_busy, f0);
      n_fail++;
    end
    n_checks++;
    src_mask = 4'b0001;
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    wait_en(1, v);
    if (v !== 4'b0001) begin
      $display("FAIL rst_mid_restart: got %b expected 0001", v);
      n_fail++;
    end
    n_checks++;
    src_done = 4'b0001;
    tick();
    src_done = 4'b0000;
    repeat (4) tick();
  endtask

  initial begin
    test_reset();
    test_two_sources();
    test_pixel_mux();
    test_timeout();
    test_done_at_timeout();
    test_back_to_back();
    test_empty_mask();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule

// File: doc/draw_sequencer.md
DRAW_SEQUENCER -- requirements
Module: draw_sequencer

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4, number of draw sources, fixed at 4 in this release.
REQ-002 SHALL have parameter TIMEOUT, default 65536, watchdog limit in cycles per source.
REQ-003 SHALL have port clk, in, 1, the single clock.
REQ-004 SHALL have port reset, in, 1, asynchronous active-high reset.
REQ-005 SHALL have port frame_req, in, 1, pulse requesting one full redraw.
REQ-006 SHALL have port src_mask, in, 4, sources to draw, sampled at frame start.
REQ-007 SHALL have port enable_draw, out, 4, one-hot start pulse to source i.
REQ-008 SHALL have port src_done, in, 4, one-cycle done pulse from source i.
REQ-009 SHALL have port src_x, in, 4x9, packed X coordinates from the sources.
REQ-010 SHALL have port src_y, in, 4x8, packed Y coordinates from the sources.
REQ-011 SHALL have port src_color, in, 4x12, packed colours from the sources.
REQ-012 SHALL have port src_we, in, 4, write enables from the sources.
REQ-013 SHALL have ports X_out (out, 9), Y_out (out, 8), Color_out (out, 12), writeEn_out (out, 1), the pixel stream to the VGA adapter.
REQ-014 SHALL have ports frame_busy, out, 1, and frame_done, out, 1 (one-cycle pulse).
REQ-015 SHALL have port timeout_err, out, 1, sticky flag that a source timed out.

Function
REQ-016 SHALL implement the states IDLE, ISSUE, WAIT_DONE, ADVANCE and FINISH.
REQ-017 IDLE SHALL go to ISSUE when frame_req or pending is 1, latch src_mask, clear pending and set idx to the lowest set mask bit.
REQ-018 IDLE with a latched mask of 0 SHALL go directly to FINISH.
REQ-019 ISSUE SHALL drive enable_draw[idx]=1 for exactly one cycle, then go to WAIT_DONE.
REQ-020 WAIT_DONE SHALL go to ADVANCE on src_done[idx]=1 or on a watchdog count of TIMEOUT-1.
- A timeout SHALL set timeout_err.
- A src_done and a timeout in the same cycle SHALL count as done, with no error.
REQ-021 ADVANCE SHALL set idx to the next higher set mask bit and go to ISSUE.
- If no higher set bit remains, it SHALL go to FINISH.
REQ-022 FINISH SHALL pulse frame_done for one cycle, then go to IDLE.
REQ-023 frame_busy SHALL be 1 in every state except IDLE.
REQ-024 frame_req while frame_busy SHALL set a one-deep pending flag; further requests SHALL be dropped.
REQ-025 src_done or src_we from any source other than idx SHALL be ignored.
REQ-026 The pixel path SHALL have exactly 1 cycle of latency: src_x, src_y, src_color and src_we of idx are registered to the outputs.
REQ-027 writeEn_out SHALL be 1 only when src_we[idx]=1 was sampled in WAIT_DONE.
REQ-028 X_out, Y_out and Color_out SHALL hold their last value when writeEn_out=0.
REQ-029 The watchdog SHALL clear on entry to WAIT_DONE and count up 1 per cycle, with a 17-bit width.
REQ-030 The watchdog SHALL saturate at TIMEOUT-1 and never wrap.
REQ-031 timeout_err SHALL clear only on reset.
REQ-032 src_mask changes during a frame SHALL have no effect until the next frame.

Reset
REQ-033 On reset, the state SHALL be IDLE and idx, pending and the watchdog SHALL be 0.
REQ-034 On reset, enable_draw, writeEn_out, frame_busy, frame_done and timeout_err SHALL be 0.
REQ-035 On reset, X_out, Y_out and Color_out SHALL be 0.
REQ-036 Reset mid-frame SHALL abort immediately with no frame_done pulse.
- Sources are expected to share this reset.

Structure
REQ-037 A shared package SHALL hold the state encoding, the widths (X 9, Y 8, colour 12) and the NUM_SRC and TIMEOUT defaults.
REQ-038 The watchdog SHALL be a sub-module draw_watchdog with ports clk, reset, clear, expired.
REQ-039 The FSM and the pixel mux SHALL stay in draw_sequencer.

Verification
REQ-040 Scenario: src_mask=4'b0101, sources done after 10 and 20 cycles.
- Required: enable_draw pulses 0001 then 0100.
- Required: one frame_done; timeout_err stays 0.
REQ-041 Scenario: source 1 streams (x=100, y=60, color=12'hF00, we=1) while idx=1.
- Required: X_out=100, Y_out=60, Color_out=F00, writeEn_out=1 exactly 1 cycle later.
- Required: source 2 we=1 during the same window produces no write.
REQ-042 Scenario: TIMEOUT=16, source 0 never asserts done.
- Required: ADVANCE after 16 WAIT_DONE cycles; timeout_err=1 and remains 1.
REQ-043 Scenario: three frame_req pulses while busy.
- Required: exactly two frames total are drawn, i.e. two frame_done pulses.
REQ-044 Scenario: src_mask=0 then frame_req.
- Required: frame_done 2 cycles later; enable_draw never asserted.
REQ-045 Scenario: reset asserted while in WAIT_DONE of source 2.
- Required: all outputs 0 asynchronously; IDLE after release.
